// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key synchroniser, stability-counter debounce and press/release pulses.
// Optional `KEY_MUTEX_EN adds single-owner lockout so only one key is visible at a time.
module key_conditioner #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY_raw,
  output logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] released,
  output logic                any_held
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_KEYS-1:0] sync;
  logic [NUM_KEYS-1:0] stable_q;
  logic [NUM_KEYS-1:0] stable_n;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_n [NUM_KEYS];
  logic [NUM_KEYS-1:0] fall;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] pressed_n;
  logic [NUM_KEYS-1:0] released_n;

  // Synchroniser chain; resets to idle (1) so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
    end else begin
      sync_q[0] <= KEY_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Stability counter: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_n = stable_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_n[i] = '0;
      if (sync[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_n[i] = sync[i];
        else                                         cnt_n[i]    = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '1;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_n;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_n[i];
    end
  end

  assign fall = stable_q & ~stable_n;
  assign rise = ~stable_q & stable_n;

`ifdef KEY_MUTEX_EN
  localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t              state;
  logic [IDX_W-1:0]    owner;
  logic [NUM_KEYS-1:0] blocked;
  logic [NUM_KEYS-1:0] blocked_n;
  logic [NUM_KEYS-1:0] lock;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant_idx;

  // Highest-index falling key wins the grant; any other key held meanwhile stays blocked until released.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (fall[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      lock[i] = (state == ST_OWNED) ? (owner != IDX_W'(i))
                                    : (grant_vld && (grant_idx != IDX_W'(i)));
    end
    blocked_n  = ~stable_n & (blocked | lock);
    key_n      = stable_n | blocked_n;
    pressed_n  = fall & ~blocked_n;
    released_n = rise & ~blocked;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= '0;
      blocked <= '0;
    end else begin
      blocked <= blocked_n;
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            state <= ST_OWNED;
            owner <= grant_idx;
          end
        end
        ST_OWNED: begin
          if (rise[owner]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  always_comb begin
    key_n      = stable_n;
    pressed_n  = fall;
    released_n = rise;
  end
`endif

  // Registered outputs change on the same edge as the debounced level.
  always_ff @(posedge clk) begin
    if (reset) begin
      KEY      <= '1;
      pressed  <= '0;
      released <= '0;
      any_held <= 1'b0;
    end else begin
      KEY      <= key_n;
      pressed  <= pressed_n;
      released <= released_n;
      any_held <= |(~key_n);
    end
  end

endmodule
